hi_lo_unit: RTL
===============

# hi_lo_unit

Iterative multiply/divide unit and HI/LO register pair for the MIPS core, sitting in the execute stage beside the ALU. It executes the four R-type instructions that the control unit flags with `hi_lo_register_write`: MULT, MULTU, DIV and DIVU. It also handles the MTHI/MTLO register writes. While an operation is in flight it raises `busy` so the pipeline can stall MFHI/MFLO and further HI/LO writers.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  the control unit's `hi_lo_register_write`; qualifies `funct` for one cycle.
- `funct`  in  6  instruction[5:0].
- `operand_a`  in  32  rs value (multiplicand / dividend / MTHI-MTLO source).
- `operand_b`  in  32  rt value (multiplier / divisor).
- `hi`  out  32  HI register, registered.
- `lo`  out  32  LO register, registered.
- `busy`  out  1  high whenever state ≠ IDLE; decoded from state, no added latency.

## Operation

Recognised `funct` values:
- MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- MTHI 0x11, MTLO 0x13.
- `start` with any other `funct` is ignored.

State machine:
- **IDLE**
  - `start` & MUL/DIV funct → latch signedness, result signs and operand magnitudes; set counter = 31; go to MUL or DIV.
  - `start` & MTHI → `hi` ← `operand_a` next edge; stay IDLE.
  - `start` & MTLO → `lo` ← `operand_a` next edge; stay IDLE.
- **MUL**
  - Radix-2 shift-add, one bit per cycle, into a 64-bit accumulator.
  - At counter = 0 go to FIX; otherwise decrement.
- **DIV**
  - Radix-2 restoring division, one quotient bit per cycle.
  - At counter = 0 go to FIX.
- **FIX**
  - Apply sign correction and write `hi`/`lo`; return to IDLE.
  - MULT: 64-bit product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Unsigned ops: no correction.

Arithmetic rules:
- Results are bit-exact MIPS32: `hi` = upper product word or remainder; `lo` = lower word or quotient.
- Signed magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31.
- DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0 (wraps, no trap).
- Divide by zero, signed or unsigned → `lo` = 0xFFFFFFFF, `hi` = `operand_a` as latched. Latency is unchanged and sign correction is skipped.

Boundary behaviour:
- `start` while `busy`: ignored entirely, including MTHI/MTLO. The pipeline must stall.
- Operands are latched at acceptance; later changes on `operand_a`/`operand_b` have no effect.
- `reset` in any state, including mid-operation: next edge gives IDLE, `hi` = `lo` = 0, `busy` = 0. The partial result is discarded.

## Timing

- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, state IDLE.
- MUL/DIV, with `start` sampled at edge 0:
  - `busy` is high in cycles 1–33 (32 iteration cycles plus FIX).
  - New `hi`/`lo` are visible and `busy` is low from cycle 34.
  - Latency 34 cycles.
- Back-to-back: a second `start` is accepted at cycle 34 at the earliest.
- MTHI/MTLO: the value is visible the cycle after `start`; `busy` never rises.
- `hi`/`lo` hold their old values throughout MUL/DIV/FIX until the FIX edge.

## Structure

Shared package `mips_pkg` holds:
- funct constants: `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_MTHI`, `FUNCT_MTLO`. These are shared with the control unit.
- the state enum `hilo_state_t` {IDLE, MUL, DIV, FIX}.

Module layout:
- Single module, no sub-module.
- The shift-add and restoring-divide datapaths share one 64-bit working register and one 32-bit adder/subtractor.

## Test plan

1. Reset, then idle with `start` = 0 → `hi` = `lo` = 0, `busy` = 0; `reset` asserted at cycle 10 of a DIV → IDLE and zeros on the next cycle.
2. MULTU 0xFFFFFFFF × 0xFFFFFFFF → `busy` high cycles 1–33; cycle 34: `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
3. MULT −3 × 7 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
4. DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
5. Divide edge cases, each with latency 34:
   - DIVU 7 / 0 → `lo` = 0xFFFFFFFF, `hi` = 7.
   - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
6. Writes and collisions:
   - MTHI 0x12345678 in IDLE → `hi` updated next cycle.
   - MTLO and MULT issued while `busy` → ignored; `hi`/`lo` end with the first operation's result.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS funct codes and HI/LO unit state encoding
//
// Purpose: constants shared between the control unit and the HI/LO unit.
// Ports:   none (package).

package mips_pkg;

   // R-type funct codes that write HI/LO
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } hilo_state_t;

endpackage

// File: rtl/hi_lo_unit.sv
// rtl/hi_lo_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO register pair
//
// Purpose: executes the HI/LO writers of the MIPS execute stage. Multiplies by
//          radix-2 shift-add and divides by radix-2 restoring division, one bit
//          per cycle, on magnitudes; a final FIX cycle applies sign correction.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      qualifies funct for one cycle (ignored while busy)
//   funct      instruction[5:0]
//   operand_a  rs: multiplicand / dividend / MTHI-MTLO source
//   operand_b  rt: multiplier / divisor
//   hi, lo     registered HI/LO
//   busy       high whenever the unit is not IDLE

module hi_lo_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);

   localparam int                 CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]      CNT_ZERO = '0;
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [WIDTH-1:0]   ONES_W   = '1;
   localparam logic [WIDTH-1:0]   ZERO_W   = '0;
   localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

   hilo_state_t state, state_next;

   logic [CW-1:0]      count;
   // Shared working register: {accumulator/remainder, multiplier/dividend}
   logic [2*WIDTH-1:0] work, work_next;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   a_raw;
   logic               div_op;
   logic               neg_main;   // product / quotient must be negated
   logic               neg_rem;    // remainder takes the dividend's sign
   logic               div_zero;

   // ---------------- decode of the incoming instruction ----------------
   logic             op_mul, op_div, op_signed, a_neg, b_neg, accept;
   logic [WIDTH-1:0] a_mag, b_mag_in;

   always_comb begin
      op_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
      op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
      op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
      a_neg     = op_signed & operand_a[WIDTH-1];
      b_neg     = op_signed & operand_b[WIDTH-1];
      // 0x80000000 negates to itself, which is exactly the unsigned 2^31 wanted
      a_mag     = a_neg ? (~operand_a + ONE_W) : operand_a;
      b_mag_in  = b_neg ? (~operand_b + ONE_W) : operand_b;
      accept    = start && (state == IDLE);
   end

   // ---------------- shared adder / subtractor ----------------
   // MUL: upper half + multiplicand. DIV: {remainder, next dividend bit} - divisor,
   // where the carry out of the extra top bit means "no borrow".
   logic [WIDTH:0]   add_x, add_y;
   logic             add_cin;
   logic [WIDTH+1:0] add_sum;

   always_comb begin
      if (state == DIV) begin
         add_x   = work[2*WIDTH-1:WIDTH-1];
         add_y   = ~{1'b0, b_mag};
         add_cin = 1'b1;
      end else begin
         add_x   = {1'b0, work[2*WIDTH-1:WIDTH]};
         add_y   = {1'b0, b_mag};
         add_cin = 1'b0;
      end
      add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
   end

   always_comb begin
      work_next = work;
      if (state == MUL) begin
         work_next = work[0] ? {add_sum[WIDTH:0], work[WIDTH-1:1]}
                             : {1'b0, work[2*WIDTH-1:1]};
      end else if (state == DIV) begin
         work_next = add_sum[WIDTH+1] ? {add_sum[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                                      : {work[2*WIDTH-2:0], 1'b0};
      end
   end

   // ---------------- sign correction for the FIX cycle ----------------
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quo_neg, rem_neg, fix_hi, fix_lo;

   always_comb begin
      prod_neg = ~work + ONE_2W;
      quo_neg  = ~work[WIDTH-1:0] + ONE_W;
      rem_neg  = ~work[2*WIDTH-1:WIDTH] + ONE_W;
      fix_hi   = work[2*WIDTH-1:WIDTH];
      fix_lo   = work[WIDTH-1:0];
      if (!div_op) begin
         if (neg_main) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
         end
      end else if (div_zero) begin
         fix_hi = a_raw;
         fix_lo = ONES_W;
      end else begin
         if (neg_main) fix_lo = quo_neg;
         if (neg_rem)  fix_hi = rem_neg;
      end
   end

   // ---------------- state machine ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && op_mul)      state_next = MUL;
            else if (accept && op_div) state_next = DIV;
         end
         MUL, DIV: begin
            if (count == CNT_ZERO) state_next = FIX;
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // ---------------- datapath and HI/LO registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         hi       <= ZERO_W;
         lo       <= ZERO_W;
         work     <= '0;
         count    <= CNT_ZERO;
         b_mag    <= ZERO_W;
         a_raw    <= ZERO_W;
         div_op   <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (funct == FUNCT_MTHI) hi <= operand_a;
                  if (funct == FUNCT_MTLO) lo <= operand_a;
                  if (op_mul || op_div) begin
                     work     <= {ZERO_W, a_mag};
                     b_mag    <= b_mag_in;
                     a_raw    <= operand_a;
                     count    <= CNT_LAST;
                     div_op   <= op_div;
                     neg_main <= a_neg ^ b_neg;
                     neg_rem  <= a_neg;
                     div_zero <= op_div && (operand_b == ZERO_W);
                  end
               end
            end
            MUL, DIV: begin
               work <= work_next;
               if (count != CNT_ZERO) count <= count - CNT_ONE;
            end
            FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
